serial_shift_deserializer: RTL and testbench
============================================

// Module: serial_shift_deserializer
// PURPOSE
//   Receive end of the shift datapath: collects a serial bit stream one bit per accepted cycle into a
//   WIDTH-bit word, MSB-first or LSB-first, and presents it on a parallel valid/ready output.
//   Sits downstream of the shift/serialiser stage and feeds the ALU operand registers.
//   Assembly and output are double-buffered, so a new word shifts in while the previous one waits.
// PARAMETERS
//   WIDTH   4   word width in bits (>= 2); bit counter is $clog2(WIDTH+1) bits wide
// PORTS
//   clock        in   1      single clock; all logic on posedge clock
//   reset        in   1      synchronous, active-high reset
//   ser_in       in   1      serial data bit
//   ser_valid    in   1      ser_in is accepted on every posedge where ser_valid=1; no backpressure
//   right_shift  in   1      word order: 1 = LSB-first (shift right, new bit enters MSB), 0 = MSB-first
//   data_out     out  WIDTH  assembled word, held stable while out_valid=1
//   out_valid    out  1      data_out holds an unconsumed word
//   out_ready    in   1      consumer accepts data_out on the posedge where out_valid & out_ready
//   busy         out  1      1 when a word is partially received (state != IDLE)
//   overrun      out  1      sticky: a completed word was dropped because the output was full
//   parity_err   out  1      parity mismatch flag for the word on data_out (tied 0 without macro)
// BEHAVIOUR
//   Reset: data_out=0, out_valid=0, busy=0, overrun=0, parity_err=0, shift reg=0, bit_cnt=0, state=IDLE.
//   Reset asserted mid-word discards the partial word; the next accepted bit is bit 0 of a new word.
//   States: IDLE (bit_cnt=0), SHIFT (0<bit_cnt<WIDTH), PARITY (macro only, waiting for parity bit).
//     IDLE  -> SHIFT  on ser_valid; right_shift latched into dir_q here and used for the whole word.
//     SHIFT -> SHIFT  on ser_valid while bit_cnt+1 < WIDTH; ser_valid=0 holds state and count (gaps allowed).
//     SHIFT -> IDLE   on ser_valid with bit_cnt+1 = WIDTH (word complete); -> PARITY instead if macro on.
//     PARITY-> IDLE   on ser_valid (parity bit accepted, word complete).
//   Shift per accepted bit: dir_q=1: sreg <= {ser_in, sreg[WIDTH-1:1]};
//     dir_q=0: sreg <= {sreg[WIDTH-2:0], ser_in}.
//   Word complete: the word includes the completing bit. Latency: out_valid=1 on the posedge after
//     the final bit is accepted.
//   Output handshake, evaluated on each posedge:
//     out_valid & out_ready & !complete     -> out_valid <= 0.
//     complete & (!out_valid | out_ready)   -> data_out <= word, out_valid <= 1 (back-to-back OK).
//     complete & out_valid & !out_ready     -> word dropped, data_out unchanged, overrun <= 1.
//   overrun clears only on reset. right_shift changes mid-word have no effect until the next word.
//   Accepting bit 0 of the next word while out_valid is pending is legal.
// CONFIGURATION
//   DESER_PARITY_CHECK_EN defined: after WIDTH data bits, one extra accepted bit is an even-parity
//     bit (XOR of data bits). Completion occurs on the parity bit. parity_err is loaded with data_out
//     (1 = mismatch). The word is still delivered on mismatch. A dropped word does not update parity_err.
//   Not defined: no PARITY state, completion occurs on data bit WIDTH, parity_err constant 0.
// TESTING (WIDTH=4)
//   Reset: hold reset for 2 cycles -> data_out=0000, out_valid=0, busy=0, overrun=0.
//   MSB-first: right_shift=0, bits 1,0,1,0 on consecutive cycles -> out_valid the cycle after the
//     4th bit, data_out=1010.
//   LSB-first: right_shift=1, bits 1,1,0,0 -> data_out=0011. Toggle right_shift after the first
//     bit -> still 0011.
//   Gaps: bits 0,1,0,1 with ser_valid low for 3 cycles between each -> data_out=0101.
//   Busy is high from bit 0 until completion.
//   Overrun: out_ready=0, send 1111 then 0001 -> data_out=1111, overrun=1. Then out_ready=1 for one
//     cycle -> out_valid=0, and overrun stays 1.
//   Reset mid-word: send bits 1,1, then reset for one cycle, then send 0,1,0,1 (MSB-first) ->
//     data_out=0101.
//   Macro on: MSB-first bits 1,0,1,0 then parity bit 1 -> data_out=1010, parity_err=1.
//     With parity bit 0 -> parity_err=0.

Source files
------------

// File: rtl/serial_shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first behind a valid/ready output.
// Optional even-parity trailer bit enabled by defining DESER_PARITY_CHECK_EN.
module serial_shift_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             right_shift,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   bit_cnt, cnt_n;
    logic [WIDTH-1:0]   sreg, sreg_n;
    logic               dir_q, dir_n, dir_eff;
    logic               shift_en;
    logic               complete;
    logic               load;

    // The first bit of a word uses right_shift directly; later bits use the latched direction.
    assign dir_eff = (state == IDLE) ? right_shift : dir_q;

    always_comb begin
        state_n  = state;
        cnt_n    = bit_cnt;
        dir_n    = dir_q;
        shift_en = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (ser_valid) begin
                    shift_en = 1'b1;
                    dir_n    = right_shift;
                    cnt_n    = CNT_W'(1);
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef DESER_PARITY_CHECK_EN
                        cnt_n   = CNT_W'(WIDTH);
                        state_n = PARITY;
`else
                        cnt_n    = '0;
                        complete = 1'b1;
                        state_n  = IDLE;
`endif
                    end else begin
                        cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (ser_valid) begin
                    cnt_n    = '0;
                    complete = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        sreg_n = sreg;
        if (shift_en) begin
            if (dir_eff) sreg_n = {ser_in, sreg[WIDTH-1:1]};
            else         sreg_n = {sreg[WIDTH-2:0], ser_in};
        end
    end

    assign load = complete && (!out_valid || out_ready);
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sreg      <= '0;
            dir_q     <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            sreg    <= sreg_n;
            dir_q   <= dir_n;
            if (load) begin
                data_out  <= sreg_n;
                out_valid <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DESER_PARITY_CHECK_EN
    logic perr_q;
    // Mismatch = XOR of the data bits disagrees with the received even-parity bit.
    always_ff @(posedge clock) begin
        if (reset)     perr_q <= 1'b0;
        else if (load) perr_q <= (^sreg) ^ ser_in;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_shift_deserializer.sv
// Directed self-checking bench for serial_shift_deserializer (WIDTH=4) with an expected-word scoreboard.
module tb_serial_shift_deserializer;
    localparam int unsigned WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             ser_in;
    logic             ser_valid;
    logic             right_shift;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    logic [WIDTH-1:0] exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    serial_shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .right_shift(right_shift),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b, input logic rs);
        @(negedge clock);
        ser_valid   = 1'b1;
        ser_in      = b;
        right_shift = rs;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            ser_valid = 1'b0;
        end
    endtask

    // seq[i] is the i-th bit on the wire; MSB-first puts it at WIDTH-1-i, LSB-first at i.
    task automatic send_word(input logic [WIDTH-1:0] seq, input logic dir, input int gap_n,
                             input bit toggle, input bit push, input bit par_flip);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir) w[i] = seq[i];
            else     w[WIDTH-1-i] = seq[i];
        end
        if (push) exp_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) begin
            send(seq[i], (toggle && i > 0) ? ~dir : dir);
            if (gap_n > 0 && i < WIDTH - 1) begin
                idle(gap_n);
                chk("busy_gap", {31'b0, busy}, 32'd1);
            end
        end
`ifdef DESER_PARITY_CHECK_EN
        send((^seq) ^ par_flip, dir);
`else
        if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    endtask

    task automatic wait_word(input string tag);
        bit got = 1'b0;
        logic [WIDTH-1:0] e;
        for (int i = 0; i < 16; i++) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            idle(1);
        end
        chk({tag, "_seen"}, {31'b0, got}, 32'd1);
        if (got) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk(tag, {28'b0, data_out}, {28'b0, e});
            end
        end
    endtask

    initial begin
        reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; right_shift = 1'b0; out_ready = 1'b1;
        idle(2);
        chk("rst_data",    {28'b0, data_out}, 32'h0);
        chk("rst_valid",   {31'b0, out_valid}, 32'd0);
        chk("rst_busy",    {31'b0, busy}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_parity",  {31'b0, parity_err}, 32'd0);
        reset = 1'b0;

        // MSB-first 1,0,1,0 with exact one-cycle latency
        send_word(4'b0101, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("msb_latency", {31'b0, out_valid}, 32'd1);
        chk("msb_busy_done", {31'b0, busy}, 32'd0);
        wait_word("msb");
        idle(1);
        chk("msb_consumed", {31'b0, out_valid}, 32'd0);

        // LSB-first 1,1,0,0 -> 0011, then again toggling right_shift mid-word
        send_word(4'b0011, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        idle(1);
        wait_word("lsb");
        send_word(4'b0011, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        idle(1);
        wait_word("lsb_toggle");

        // MSB-first 0,1,0,1 with 3-cycle gaps -> 0101
        send_word(4'b1010, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("gap_busy_done", {31'b0, busy}, 32'd0);
        wait_word("gaps");
        idle(1);

        // Overrun: 1111 held, 0001 dropped
        out_ready = 1'b0;
        send_word(4'b1111, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("ovr_first_valid", {31'b0, out_valid}, 32'd1);
        chk("ovr_not_yet", {31'b0, overrun}, 32'd0);
        send_word(4'b1000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("ovr_data_held", {28'b0, data_out}, 32'hF);
        chk("ovr_flag", {31'b0, overrun}, 32'd1);
        out_ready = 1'b1;
        wait_word("ovr_word");
        @(negedge clock);
        out_ready = 1'b0;
        chk("ovr_drained", {31'b0, out_valid}, 32'd0);
        chk("ovr_sticky", {31'b0, overrun}, 32'd1);
        out_ready = 1'b1;

        // Reset mid-word discards the partial 1,1
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        @(negedge clock);
        ser_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_overrun", {31'b0, overrun}, 32'd0);
        send_word(4'b1010, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1);
        wait_word("midrst");
        idle(1);

`ifdef DESER_PARITY_CHECK_EN
        send_word(4'b0101, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle(1);
        chk("par_err_set", {31'b0, parity_err}, 32'd1);
        wait_word("par_bad");
        send_word(4'b0101, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("par_err_clr", {31'b0, parity_err}, 32'd0);
        wait_word("par_good");
        idle(1);
`endif

        chk("sb_empty", exp_q.size(), 32'd0);
        chk("end_valid", {31'b0, out_valid}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
